// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and legal parameter ranges.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;

    localparam int DATA_W_MIN     = 5;
    localparam int DATA_W_MAX     = 9;
    localparam int OS_RATE_MIN    = 4;
    localparam int STOP_BITS_MAX  = 2;
    localparam int FIFO_DEPTH_MIN = 2;

    function automatic bit is_pow2(input int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO; a pop frees the slot for a push on the same edge.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = r_count == CW'(DEPTH);
    assign o_empty   = r_count == '0;
    assign o_count   = r_count;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable framing,
// runtime parity and a show-ahead receive FIFO with sticky error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int OS_RATE    = 16,
    parameter  int STOP_BITS  = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rxd,
    input  logic              i_os_tick,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_rd_en,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [CW-1:0]     o_fifo_count,
    output logic              o_rx_busy,
    output logic              o_frame_err,
    output logic              o_parity_err,
    output logic              o_overrun
);
    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_MID  = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("DATA_W must be 5..9");
    end
    if (OS_RATE < OS_RATE_MIN || OS_RATE % 2 != 0) begin : g_bad_os_rate
        $error("OS_RATE must be even and >= 4");
    end
    if (STOP_BITS < 1 || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < FIFO_DEPTH_MIN || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, >= 2");
    end

    rx_state_t         r_state, w_state_nx;
    logic [1:0]        r_sync;
    logic [TW-1:0]     r_tick, w_tick_nx;
    logic [BW-1:0]     r_bit, w_bit_nx;
    logic [DATA_W-1:0] r_shift, w_shift_nx;
    logic              r_par_en, w_par_en_nx;
    logic              r_par_odd, w_par_odd_nx;
    logic              r_par_bad, w_par_bad_nx;
    logic              r_stop_bad, w_stop_bad_nx;
    logic              r_frame_err, r_parity_err, r_overrun;
    logic              w_rxd, w_mid, w_push, w_fe, w_pe, w_ov, w_full, w_empty;

    assign w_rxd        = r_sync[1];
    assign w_mid        = i_os_tick && (r_tick == (r_state == START ? TICK_MID : TICK_END));
    assign w_ov         = w_push && w_full && !i_rd_en;
    assign o_rd_valid   = !w_empty;
    assign o_rx_busy    = r_state != IDLE;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 2'b11;
            r_state      <= IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_rxd};
            r_state      <= w_state_nx;
            r_tick       <= w_tick_nx;
            r_bit        <= w_bit_nx;
            r_shift      <= w_shift_nx;
            r_par_en     <= w_par_en_nx;
            r_par_odd    <= w_par_odd_nx;
            r_par_bad    <= w_par_bad_nx;
            r_stop_bad   <= w_stop_bad_nx;
            // A flag being set outranks a simultaneous clear.
            r_frame_err  <= w_fe | (r_frame_err & ~i_err_clr);
            r_parity_err <= w_pe | (r_parity_err & ~i_err_clr);
            r_overrun    <= w_ov | (r_overrun & ~i_err_clr);
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_tick_nx     = (i_os_tick && r_state != IDLE && r_state != WAIT_HIGH) ? r_tick + 1'b1 : r_tick;
        w_bit_nx      = r_bit;
        w_shift_nx    = r_shift;
        w_par_en_nx   = r_par_en;
        w_par_odd_nx  = r_par_odd;
        w_par_bad_nx  = r_par_bad;
        w_stop_bad_nx = r_stop_bad;
        w_push        = 1'b0;
        w_fe          = 1'b0;
        w_pe          = 1'b0;
        case (r_state)
            IDLE: if (!w_rxd) begin
                w_state_nx = START;
                w_tick_nx  = '0;
            end
            START: if (w_mid) begin
                w_tick_nx     = '0;
                w_bit_nx      = '0;
                w_par_en_nx   = i_parity_en;
                w_par_odd_nx  = i_parity_odd;
                w_par_bad_nx  = 1'b0;
                w_stop_bad_nx = 1'b0;
                w_state_nx    = w_rxd ? IDLE : DATA;
            end
            DATA: if (w_mid) begin
                w_tick_nx  = '0;
                w_shift_nx = {w_rxd, r_shift[DATA_W-1:1]};
                w_bit_nx   = r_bit == LAST_BIT ? '0 : r_bit + 1'b1;
                if (r_bit == LAST_BIT) w_state_nx = r_par_en ? PARITY : STOP;
            end
            PARITY: if (w_mid) begin
                w_tick_nx    = '0;
                w_par_bad_nx = (^r_shift ^ w_rxd) != r_par_odd;
                w_state_nx   = STOP;
            end
            STOP: if (w_mid) begin
                w_tick_nx     = '0;
                w_bit_nx      = r_bit + 1'b1;
                w_stop_bad_nx = r_stop_bad | !w_rxd;
                if (r_bit == LAST_STOP) begin
                    w_bit_nx = '0;
                    // A low stop bit may be a break; wait for the line to recover.
                    if (r_stop_bad || !w_rxd) begin
                        w_fe       = 1'b1;
                        w_state_nx = WAIT_HIGH;
                    end else begin
                        w_pe       = r_par_bad;
                        w_push     = !r_par_bad;
                        w_state_nx = IDLE;
                    end
                end
            end
            WAIT_HIGH: if (w_rxd) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (i_rd_en),
        .i_wdata (r_shift),
        .o_rdata (o_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scenario tasks driving serial frames against a queue-based
// model of the receive FIFO and sticky flags.
module tb_uart_rx_param;
    localparam int DATA_W     = 8;
    localparam int OS_RATE    = 16;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int P          = 4;
    localparam int MID        = OS_RATE / 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    logic clk = 0, rst_n = 0, rxd = 1, os_tick = 0;
    logic parity_en = 0, parity_odd = 0, rd_en = 0, err_clr = 0;
    logic [DATA_W-1:0] rd_data;
    logic [CW-1:0]     fifo_count;
    logic rd_valid, rx_busy, frame_err, parity_err, overrun;

    int checks = 0, errors = 0;
    logic [DATA_W-1:0] m_q[$];
    logic m_fe = 0, m_pe = 0, m_ov = 0;
    logic pre_valid, post_valid, had_pop;
    logic [DATA_W-1:0] pop_data, exp_pop;

    uart_rx_param #(.DATA_W(DATA_W), .OS_RATE(OS_RATE), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_rxd(rxd), .i_os_tick(os_tick), .i_parity_en(parity_en),
        .i_parity_odd(parity_odd), .i_rd_en(rd_en), .i_err_clr(err_clr), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .o_fifo_count(fifo_count), .o_rx_busy(rx_busy),
        .o_frame_err(frame_err), .o_parity_err(parity_err), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    // n oversample periods of level b; act 1 pops, act 2 clears flags on the mid-bit tick
    task automatic drive_sub(input logic b, input int n, input int act);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == 0) rxd = b;
            os_tick = 1;
            if (j == MID) begin
                pre_valid = rd_valid;
                pop_data  = rd_data;
                rd_en     = (act == 1);
                err_clr   = (act == 2);
            end
            @(negedge clk);
            os_tick = 0; rd_en = 0; err_clr = 0;
            if (j == MID) post_valid = rd_valid;
            repeat (P - 2) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic pen, input logic podd,
                              input logic flip, input logic stop0, input int act);
        parity_en = pen; parity_odd = podd;
        drive_sub(1'b0, OS_RATE, 0);
        parity_en = 1'($urandom); parity_odd = 1'($urandom);
        for (int i = 0; i < DATA_W; i++) drive_sub(d[i], OS_RATE, 0);
        if (pen) drive_sub(^d ^ podd ^ flip, OS_RATE, 0);
        for (int s = 0; s < STOP_BITS; s++)
            drive_sub(s == 0 ? stop0 : 1'b1, OS_RATE, s == STOP_BITS - 1 ? act : 0);
        had_pop = 0;
        if (act == 1 && m_q.size() > 0) begin exp_pop = m_q.pop_front(); had_pop = 1; end
        if (act == 2) begin m_fe = 0; m_pe = 0; m_ov = 0; end
        if (!stop0) m_fe = 1;
        else if (pen && flip) m_pe = 1;
        else if (m_q.size() == FIFO_DEPTH) m_ov = 1;
        else m_q.push_back(d);
    endtask

    task automatic do_pop(output logic [DATA_W-1:0] got, output logic gv,
                          output logic [DATA_W-1:0] exp, output logic ev);
        @(negedge clk);
        got = rd_data; gv = rd_valid;
        ev  = m_q.size() > 0;
        exp = ev ? m_q[0] : '0;
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
        if (ev) void'(m_q.pop_front());
    endtask

    task automatic clear_errs();
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
        m_fe = 0; m_pe = 0; m_ov = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_valid, fifo_count, rx_busy, frame_err, parity_err, overrun} !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset got valid=%b cnt=%0d busy=%b flags=%b%b%b data=%h exp all 0",
                     rd_valid, fifo_count, rx_busy, frame_err, parity_err, overrun, rd_data);
        end
        rst_n = 1;
        drive_sub(1'b1, OS_RATE, 0);
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] g, e; logic gv, ev;
        send_frame(8'hA5, 0, 0, 0, 1, 0);
        checks++;
        if (pre_valid !== 1'b0 || post_valid !== 1'b1) begin
            errors++; $display("FAIL latency got pre=%b post=%b exp pre=0 post=1", pre_valid, post_valid);
        end
        checks++;
        if (rd_data !== 8'hA5 || fifo_count !== CW'(1)) begin
            errors++; $display("FAIL basic_head got %h cnt %0d exp a5 cnt 1", rd_data, fifo_count);
        end
        checks++;
        if ({frame_err, parity_err, overrun} !== 3'b000) begin
            errors++; $display("FAIL basic_flags got %b%b%b exp 000", frame_err, parity_err, overrun);
        end
        do_pop(g, gv, e, ev);
        checks++;
        if (g !== e || gv !== ev || rd_valid !== 1'b0 || fifo_count !== '0) begin
            errors++; $display("FAIL basic_pop got %h/%b after valid=%b cnt=%0d exp %h/%b 0 0", g, gv, rd_valid, fifo_count, e, ev);
        end
    endtask

    task automatic test_false_start();
        drive_sub(1'b0, 6, 0);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy got %b exp 1", rx_busy); end
        drive_sub(1'b1, 2 * OS_RATE, 0);
        checks++;
        if (rx_busy !== 1'b0 || fifo_count !== '0 || {frame_err, parity_err, overrun} !== 3'b000) begin
            errors++; $display("FAIL false_start got busy=%b cnt=%0d flags=%b%b%b exp 0 0 000", rx_busy, fifo_count, frame_err, parity_err, overrun);
        end
    endtask

    task automatic test_parity();
        logic [DATA_W-1:0] g, e; logic gv, ev;
        send_frame(8'h03, 1, 0, 1, 1, 0);
        checks++;
        if (parity_err !== 1'b1 || fifo_count !== '0) begin
            errors++; $display("FAIL parity_bad got perr=%b cnt=%0d exp 1 0", parity_err, fifo_count);
        end
        send_frame(8'h03, 1, 0, 0, 1, 0);
        send_frame(8'hC4, 1, 1, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            do_pop(g, gv, e, ev);
            checks++;
            if (g !== e || gv !== ev) begin errors++; $display("FAIL parity_pop%0d got %h/%b exp %h/%b", k, g, gv, e, ev); end
        end
        clear_errs();
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clr got %b exp 0", parity_err); end
        send_frame(8'h81, 1, 1, 1, 1, 2);
        checks++;
        if (parity_err !== m_pe) begin errors++; $display("FAIL set_wins got %b exp %b", parity_err, m_pe); end
        clear_errs();
    endtask

    task automatic test_frame_err();
        logic [DATA_W-1:0] g, e; logic gv, ev;
        send_frame(8'h55, 0, 0, 0, 0, 0);
        drive_sub(1'b0, 2 * OS_RATE, 0);
        checks++;
        if (frame_err !== m_fe || rx_busy !== 1'b1 || fifo_count !== CW'(m_q.size())) begin
            errors++; $display("FAIL frame_err got fe=%b busy=%b cnt=%0d exp %b 1 %0d", frame_err, rx_busy, fifo_count, m_fe, m_q.size());
        end
        drive_sub(1'b1, 2 * OS_RATE, 0);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL wait_high_exit got busy=%b exp 0", rx_busy); end
        send_frame(8'h3C, 0, 0, 0, 1, 0);
        do_pop(g, gv, e, ev);
        checks++;
        if (g !== e || gv !== ev) begin errors++; $display("FAIL after_break got %h/%b exp %h/%b", g, gv, e, ev); end
        clear_errs();
    endtask

    task automatic test_overrun();
        logic [DATA_W-1:0] g, e; logic gv, ev;
        for (int k = 1; k <= 5; k++) send_frame(DATA_W'(k), 0, 0, 0, 1, 0);
        checks++;
        if (fifo_count !== CW'(FIFO_DEPTH) || overrun !== m_ov) begin
            errors++; $display("FAIL overrun got cnt=%0d ov=%b exp %0d %b", fifo_count, overrun, FIFO_DEPTH, m_ov);
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            do_pop(g, gv, e, ev);
            checks++;
            if (g !== e || gv !== ev) begin errors++; $display("FAIL ov_pop%0d got %h/%b exp %h/%b", k, g, gv, e, ev); end
        end
        clear_errs();
        for (int k = 1; k <= 5; k++) send_frame(DATA_W'(k), 0, 0, 0, 1, k == 5 ? 1 : 0);
        checks++;
        if (had_pop !== 1'b1 || pop_data !== exp_pop || overrun !== 1'b0 || fifo_count !== CW'(FIFO_DEPTH)) begin
            errors++; $display("FAIL push_pop_full got head=%h ov=%b cnt=%0d exp %h 0 %0d", pop_data, overrun, fifo_count, exp_pop, FIFO_DEPTH);
        end
        while (m_q.size() > 0) begin
            do_pop(g, gv, e, ev);
            checks++;
            if (g !== e || gv !== ev) begin errors++; $display("FAIL drain got %h/%b exp %h/%b", g, gv, e, ev); end
        end
        do_pop(g, gv, e, ev);
        checks++;
        if (gv !== 1'b0 || fifo_count !== '0) begin
            errors++; $display("FAIL empty_pop got valid=%b cnt=%0d exp 0 0", gv, fifo_count);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] g, e; logic gv, ev;
        for (int n = 0; n < 16; n++) begin
            send_frame(DATA_W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 1, 0);
            checks++;
            if (fifo_count !== CW'(m_q.size()) || {frame_err, parity_err, overrun} !== {m_fe, m_pe, m_ov}) begin
                errors++; $display("FAIL rand%0d got cnt=%0d flags=%b%b%b exp %0d %b%b%b", n, fifo_count,
                                   frame_err, parity_err, overrun, m_q.size(), m_fe, m_pe, m_ov);
            end
            if ($urandom_range(0, 2) != 0) begin
                do_pop(g, gv, e, ev);
                checks++;
                if (g !== e || gv !== ev) begin errors++; $display("FAIL rand_pop%0d got %h/%b exp %h/%b", n, g, gv, e, ev); end
            end
        end
        while (m_q.size() > 0) do_pop(g, gv, e, ev);
        clear_errs();
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] g, e; logic gv, ev;
        send_frame(8'h11, 0, 0, 0, 1, 0);
        send_frame(8'h22, 1, 0, 1, 1, 0);
        drive_sub(1'b0, OS_RATE, 0);
        drive_sub(1'b1, 3 * OS_RATE, 0);
        @(negedge clk); #2 rst_n = 0;
        #1;
        checks++;
        if ({rd_valid, fifo_count, rx_busy, frame_err, parity_err, overrun} !== '0 || rd_data !== '0) begin
            errors++; $display("FAIL mid_reset got valid=%b cnt=%0d busy=%b flags=%b%b%b data=%h exp all 0",
                               rd_valid, fifo_count, rx_busy, frame_err, parity_err, overrun, rd_data);
        end
        m_q.delete(); m_fe = 0; m_pe = 0; m_ov = 0;
        @(negedge clk); rst_n = 1;
        drive_sub(1'b1, 2 * OS_RATE, 0);
        checks++;
        if (fifo_count !== '0 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL no_push_after_reset got cnt=%0d busy=%b exp 0 0", fifo_count, rx_busy);
        end
        send_frame(8'h5A, 0, 0, 0, 1, 0);
        do_pop(g, gv, e, ev);
        checks++;
        if (g !== e || gv !== ev || e !== 8'h5A) begin errors++; $display("FAIL post_reset got %h/%b exp 5a", g, gv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_parity();
        test_frame_err();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
